oled_draw_arbiter: RTL and testbench

//  Shares the single glyph draw engine between NREQ character sources (fixed text, dynamic text, aux).

---
 rtl/oled_draw_arbiter_if.sv | 39 +++
 rtl/oled_draw_arbiter.sv | 163 ++++++++++++++++
 tb/tb_oled_draw_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oled_draw_arbiter_if.sv
// ---------------------------------------------------------------------------
// Module   : oled_draw_arbiter_if
// Purpose  : Request/grant and engine-side bundle for the glyph draw arbiter.
//            master = character sources plus draw engine, slave = arbiter.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface oled_draw_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   req_active;
  logic [NREQ-1:0]   req_start;
  logic [8*NREQ-1:0] req_ascii;
  logic [7*NREQ-1:0] req_x;
  logic [4*NREQ-1:0] req_y;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   req_busy;
  logic [NREQ-1:0]   req_done;
  logic              eng_start;
  logic [7:0]        eng_ascii;
  logic [6:0]        eng_x;
  logic [3:0]        eng_y;
  logic              eng_busy;
  logic              eng_done;
  logic              timeout_err;

  modport master (
    output req_active, req_start, req_ascii, req_x, req_y, eng_busy, eng_done,
    input  grant, req_busy, req_done, eng_start, eng_ascii, eng_x, eng_y, timeout_err
  );

  modport slave (
    input  req_active, req_start, req_ascii, req_x, req_y, eng_busy, eng_done,
    output grant, req_busy, req_done, eng_start, eng_ascii, eng_x, eng_y, timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/oled_draw_arbiter.sv
// ---------------------------------------------------------------------------
// Module   : oled_draw_arbiter
// Purpose  : Shares one glyph draw engine between NREQ character sources.
//            Session-based grant (round-robin or fixed priority), one-deep
//            start skid buffer, and a draw-done watchdog.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module oled_draw_arbiter #(
  parameter int NREQ        = 3,
  parameter int RR          = 1,
  parameter int TIMEOUT_CYC = 65535,
  parameter int TMR_W       = 16
) (
  input  logic                clk_50m,
  input  logic                rst,
  input  logic                is_run,
  oled_draw_arbiter_if.slave  bus
);

  localparam int              IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IW-1:0]    gidx;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    win;
  logic             win_vld;
  int               scan_idx;
  logic             pending;
  logic [7:0]       pend_ascii;
  logic [6:0]       pend_x;
  logic [3:0]       pend_y;
  logic [TMR_W-1:0] timer;
  logic             wd_done;

  logic             live_start;
  logic             live_active;
  logic [7:0]       live_ascii;
  logic [6:0]       live_x;
  logic [3:0]       live_y;

  // Fields of the currently granted source.
  assign live_start  = bus.req_start[gidx];
  assign live_active = bus.req_active[gidx];
  assign live_ascii  = bus.req_ascii[8*gidx +: 8];
  assign live_x      = bus.req_x[7*gidx +: 7];
  assign live_y      = bus.req_y[4*gidx +: 4];

  // Winner selection: scan upward from the source after the last released one,
  // or from index 0 when fixed priority is selected.
  always_comb begin
    win      = '0;
    win_vld  = 1'b0;
    scan_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = (RR != 0) ? ((int'(rr_ptr) + 1 + k) % NREQ) : k;
      if (!win_vld && bus.req_active[scan_idx]) begin
        win     = IW'(scan_idx);
        win_vld = 1'b1;
      end
    end
  end

  // Per-source busy/done: only the granted source sees engine status.
  always_comb begin
    bus.req_busy = '1;
    bus.req_done = '0;
    if (state != IDLE) begin
      bus.req_busy[gidx] = bus.eng_busy | (state != GRANT) | pending;
      bus.req_done[gidx] = (bus.eng_done & (state == WAIT_DONE)) | wd_done;
    end
  end

  // Session FSM: grant, forward starts (with skid), wait for done or watchdog.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      gidx            <= '0;
      rr_ptr          <= '0;
      pending         <= 1'b0;
      pend_ascii      <= '0;
      pend_x          <= '0;
      pend_y          <= '0;
      timer           <= '0;
      wd_done         <= 1'b0;
      bus.grant       <= '0;
      bus.eng_start   <= 1'b0;
      bus.eng_ascii   <= '0;
      bus.eng_x       <= '0;
      bus.eng_y       <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.eng_start <= 1'b0;
      wd_done       <= 1'b0;
      case (state)
        IDLE: begin
          if (is_run && win_vld) begin
            bus.grant <= NREQ'(1) << win;
            gidx      <= win;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if ((live_start || pending) && !bus.eng_busy) begin
            bus.eng_start <= 1'b1;
            if (pending) begin
              bus.eng_ascii <= pend_ascii;
              bus.eng_x     <= pend_x;
              bus.eng_y     <= pend_y;
            end else begin
              bus.eng_ascii <= live_ascii;
              bus.eng_x     <= live_x;
              bus.eng_y     <= live_y;
            end
            pending <= 1'b0;
            timer   <= '0;
            state   <= WAIT_DONE;
          end else if (live_start && !pending) begin
            // Engine still busy: park the request in the skid register.
            pending    <= 1'b1;
            pend_ascii <= live_ascii;
            pend_x     <= live_x;
            pend_y     <= live_y;
          end else if (!live_active && !pending) begin
            bus.grant <= '0;
            rr_ptr    <= gidx;
            state     <= IDLE;
          end
        end
        WAIT_DONE: begin
          // A start arriving mid-draw is kept if the skid slot is free, else dropped.
          if (live_start && !pending) begin
            pending    <= 1'b1;
            pend_ascii <= live_ascii;
            pend_x     <= live_x;
            pend_y     <= live_y;
          end
          if (bus.eng_done) begin
            state <= GRANT;
          end else if (timer == TMR_LAST) begin
            wd_done         <= 1'b1;
            bus.timeout_err <= 1'b1;
            state           <= GRANT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_oled_draw_arbiter.sv
// ---------------------------------------------------------------------------
// Module   : tb_oled_draw_arbiter
// Purpose  : Self-checking bench for oled_draw_arbiter (round-robin instance
//            with a short watchdog, plus a fixed-priority instance).
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_oled_draw_arbiter;

  logic clk_50m = 1'b0;
  logic rst;
  logic is_run_a;
  logic is_run_b;

  always #5 clk_50m = ~clk_50m;

  oled_draw_arbiter_if #(.NREQ(3)) ifa ();
  oled_draw_arbiter_if #(.NREQ(3)) ifb ();

  oled_draw_arbiter #(.NREQ(3), .RR(1), .TIMEOUT_CYC(16), .TMR_W(5)) dut_a (
    .clk_50m (clk_50m),
    .rst     (rst),
    .is_run  (is_run_a),
    .bus     (ifa)
  );

  oled_draw_arbiter #(.NREQ(3), .RR(0), .TIMEOUT_CYC(16), .TMR_W(5)) dut_b (
    .clk_50m (clk_50m),
    .rst     (rst),
    .is_run  (is_run_b),
    .bus     (ifb)
  );

  int n_vec = 0;
  int n_err = 0;
  int rr_m  = 0;   // last released source of dut_a, as the model sees it

  // Reference arbitration: with rotation, the first active source strictly
  // after the last released one going around the ring; otherwise the lowest.
  function automatic int pick(input logic [2:0] act, input int last, input bit rot);
    int k;
    pick = -1;
    for (int n = 1; n <= 3; n++) begin
      k = rot ? (last + n) % 3 : n - 1;
      if (pick < 0 && act[k]) pick = k;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_50m);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_fields(input int g, input logic [7:0] a, input logic [6:0] x,
                            input logic [3:0] y);
    ifa.req_ascii = 24'($urandom);
    ifa.req_x     = 21'($urandom);
    ifa.req_y     = 12'($urandom);
    ifa.req_ascii[8*g +: 8] = a;
    ifa.req_x[7*g +: 7]     = x;
    ifa.req_y[4*g +: 4]     = y;
  endtask

  task automatic grant_next(output int g);
    cyc(); settle();
    g = pick(ifa.req_active, rr_m, 1'b1);
    chk("grant_next", ifa.grant, 32'(1 << g));
  endtask

  task automatic release_to(input int g, input logic [2:0] act_after);
    ifa.req_active = act_after;
    cyc(); settle();
    chk("release_grant", ifa.grant, 0);
    rr_m = g;
  endtask

  // One draw on granted source g; completes via eng_done or via the watchdog.
  task automatic do_draw(input int g, input logic [7:0] a, input logic [6:0] x,
                         input logic [3:0] y, input bit use_wd);
    int d;
    int n;
    set_fields(g, a, x, y);
    ifa.req_start = 3'(1 << g) | 3'($urandom);
    settle();
    chk("busy_before_start", ifa.req_busy[g], 0);
    cyc();
    ifa.req_start = '0;
    set_fields(g, 8'($urandom), 7'($urandom), 4'($urandom));
    settle();
    chk("eng_start", ifa.eng_start, 1);
    chk("eng_ascii", ifa.eng_ascii, a);
    chk("eng_x", ifa.eng_x, x);
    chk("eng_y", ifa.eng_y, y);
    chk("busy_after_start", ifa.req_busy, 3'b111);
    if (!use_wd) begin
      d = $urandom_range(1, 4);
      repeat (d) begin
        cyc(); settle();
        chk("start_one_shot", ifa.eng_start, 0);
        chk("done_early", ifa.req_done, 0);
      end
      ifa.eng_done = 1'b1;
      settle();
      chk("req_done", ifa.req_done, 32'(1 << g));
      cyc();
      ifa.eng_done = 1'b0;
      settle();
      chk("req_done_clear", ifa.req_done, 0);
    end else begin
      n = 0;
      do begin
        cyc(); settle();
        n++;
      end while (ifa.req_done == 3'b000 && n < 40);
      chk("wd_latency", n, 16);
      chk("wd_req_done", ifa.req_done, 32'(1 << g));
      chk("wd_err", ifa.timeout_err, 1);
      cyc(); settle();
      chk("wd_done_pulse", ifa.req_done, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    int g;
    int nd;
    logic [2:0] nxt;

    rst = 1'b1;
    is_run_a = 1'b0;
    is_run_b = 1'b1;
    ifa.req_active = '0; ifa.req_start = '0; ifa.req_ascii = '0; ifa.req_x = '0;
    ifa.req_y = '0; ifa.eng_busy = 1'b0; ifa.eng_done = 1'b0;
    ifb.req_active = '0; ifb.req_start = '0; ifb.req_ascii = '0; ifb.req_x = '0;
    ifb.req_y = '0; ifb.eng_busy = 1'b0; ifb.eng_done = 1'b0;
    cyc(); cyc();
    chk("rst_grant", ifa.grant, 0);
    chk("rst_eng_start", ifa.eng_start, 0);
    chk("rst_eng_ascii", ifa.eng_ascii, 0);
    chk("rst_done", ifa.req_done, 0);
    chk("rst_err", ifa.timeout_err, 0);
    rst = 1'b0;

    // Fixed priority: lowest active wins, no preemption mid-session.
    ifb.req_active = 3'b110;
    cyc(); settle();
    chk("fp_first", ifb.grant, 32'(1 << pick(3'b110, 0, 1'b0)));
    ifb.req_active = 3'b111;
    cyc(); settle();
    chk("fp_no_preempt", ifb.grant, 3'b010);
    ifb.req_active = 3'b101;
    cyc(); settle();
    chk("fp_release", ifb.grant, 0);
    cyc(); settle();
    chk("fp_low_first", ifb.grant, 32'(1 << pick(3'b101, 0, 1'b0)));
    ifb.req_active = 3'b100;
    cyc(); settle();
    chk("fp_release2", ifb.grant, 0);
    cyc(); settle();
    chk("fp_last", ifb.grant, 3'b100);
    ifb.req_active = 3'b000;
    cyc();

    // Single source; is_run dropped mid-session does not stop it.
    is_run_a = 1'b1;
    ifa.req_active = 3'b001;
    settle();
    chk("grant_latency", ifa.grant, 0);
    grant_next(g);
    is_run_a = 1'b0;
    do_draw(g, 8'h41, 7'd8, 4'd2, 1'b0);
    is_run_a = 1'b1;
    release_to(g, 3'b000);

    // Contention with rotation.
    ifa.req_active = 3'b011;
    grant_next(g);
    chk("rr_contention", g, 1);
    do_draw(g, 8'($urandom), 7'($urandom), 4'($urandom), 1'b0);
    release_to(g, 3'b001);
    grant_next(g);
    do_draw(g, 8'($urandom), 7'($urandom), 4'($urandom), 1'b0);
    release_to(g, 3'b000);

    // Randomised sessions against the rotation model.
    ifa.req_active = 3'($urandom_range(1, 7));
    grant_next(g);
    for (int s = 0; s < 20; s++) begin
      nd = $urandom_range(1, 2);
      repeat (nd) do_draw(g, 8'($urandom), 7'($urandom), 4'($urandom), 1'b0);
      nxt = 3'($urandom) & ~3'(1 << g);
      release_to(g, nxt);
      if (nxt == 3'b000) ifa.req_active = 3'($urandom_range(1, 7));
      grant_next(g);
    end

    // Busy skid: first start parked, second start dropped.
    ifa.eng_busy = 1'b1;
    set_fields(g, 8'h42, 7'd17, 4'd5);
    ifa.req_start = 3'(1 << g);
    cyc();
    ifa.req_start = '0;
    settle();
    chk("skid_no_start", ifa.eng_start, 0);
    chk("skid_busy", ifa.req_busy[g], 1);
    set_fields(g, 8'h55, 7'd3, 4'd1);
    ifa.req_start = 3'(1 << g);
    cyc();
    ifa.req_start = '0;
    set_fields(g, 8'($urandom), 7'($urandom), 4'($urandom));
    settle();
    chk("skid_hold", ifa.eng_start, 0);
    ifa.eng_busy = 1'b0;
    cyc(); settle();
    chk("skid_start", ifa.eng_start, 1);
    chk("skid_ascii", ifa.eng_ascii, 8'h42);
    chk("skid_x", ifa.eng_x, 7'd17);
    chk("skid_y", ifa.eng_y, 4'd5);
    ifa.eng_done = 1'b1;
    settle();
    chk("skid_done", ifa.req_done, 32'(1 << g));
    cyc();
    ifa.eng_done = 1'b0;
    settle();
    chk("skid_empty_busy", ifa.req_busy[g], 0);
    cyc(); settle();
    chk("skid_dropped", ifa.eng_start, 0);

    // Start during WAIT_DONE is replayed after done.
    set_fields(g, 8'h30, 7'd1, 4'd1);
    ifa.req_start = 3'(1 << g);
    cyc();
    ifa.req_start = '0;
    set_fields(g, 8'h61, 7'd99, 4'd7);
    ifa.req_start = 3'(1 << g);
    cyc();
    ifa.req_start = '0;
    set_fields(g, 8'($urandom), 7'($urandom), 4'($urandom));
    settle();
    chk("wait_capture_nostart", ifa.eng_start, 0);
    ifa.eng_done = 1'b1;
    cyc();
    ifa.eng_done = 1'b0;
    settle();
    chk("wait_pending_busy", ifa.req_busy[g], 1);
    cyc(); settle();
    chk("wait_replay_start", ifa.eng_start, 1);
    chk("wait_replay_ascii", ifa.eng_ascii, 8'h61);
    ifa.eng_done = 1'b1;
    cyc();
    ifa.eng_done = 1'b0;

    // Watchdog expiry.
    settle();
    chk("err_before_wd", ifa.timeout_err, 0);
    do_draw(g, 8'($urandom), 7'($urandom), 4'($urandom), 1'b1);

    // Session drop during a draw does not abort it.
    set_fields(g, 8'h7e, 7'd64, 4'd3);
    ifa.req_start = 3'(1 << g);
    cyc();
    ifa.req_start = '0;
    ifa.req_active = 3'b000;
    cyc(); settle();
    chk("no_abort_grant", ifa.grant, 32'(1 << g));
    ifa.eng_done = 1'b1;
    settle();
    chk("no_abort_done", ifa.req_done, 32'(1 << g));
    cyc();
    ifa.eng_done = 1'b0;
    settle();
    chk("no_abort_hold", ifa.grant, 32'(1 << g));
    cyc(); settle();
    chk("late_release", ifa.grant, 0);
    rr_m = g;
    ifa.req_active = 3'($urandom_range(1, 7));
    grant_next(g);
    chk("err_sticky", ifa.timeout_err, 1);

    // Asynchronous reset mid-draw, then is_run gating.
    set_fields(g, 8'h5a, 7'd77, 4'd9);
    ifa.req_start = 3'(1 << g);
    cyc();
    ifa.req_start = '0;
    settle();
    chk("pre_rst_start", ifa.eng_start, 1);
    rst = 1'b1;
    settle();
    chk("arst_grant", ifa.grant, 0);
    chk("arst_eng_start", ifa.eng_start, 0);
    chk("arst_eng_ascii", ifa.eng_ascii, 0);
    chk("arst_eng_x", ifa.eng_x, 0);
    chk("arst_err", ifa.timeout_err, 0);
    chk("arst_done", ifa.req_done, 0);
    cyc();
    rst = 1'b0;
    rr_m = 0;
    is_run_a = 1'b0;
    ifa.req_active = 3'b001;
    repeat (3) begin
      cyc(); settle();
      chk("is_run_block", ifa.grant, 0);
    end
    is_run_a = 1'b1;
    grant_next(g);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
